// File: rtl/seven_segment_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver_if
//
// Bundles the datapath-facing load port and the board-facing display pins of
// the seven-segment scan driver.
//
//   LD     load strobe, sampled on the rising clock edge
//   DIN    4*DIGITS hex nibbles, nibble k is digit k (digit 0 least significant)
//   DP_IN  decimal point per digit, 1 = lit
//   SEG    segment bus, active-high, SEG[7..1] = a..g, SEG[0] = dp
//   DIG    one-hot digit enable, active-high
//   PEND   shadow holds a value that is not yet on the display
//   FRAME  one-cycle pulse on every frame commit edge
//
// master: the side that loads values and watches the pins (datapath / bench)
// slave : the scan driver itself
// ---------------------------------------------------------------------------
interface seven_segment_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  LD;
    logic [4*DIGITS-1:0]   DIN;
    logic [DIGITS-1:0]     DP_IN;
    logic [7:0]            SEG;
    logic [DIGITS-1:0]     DIG;
    logic                  PEND;
    logic                  FRAME;

    modport master (
        output LD, DIN, DP_IN,
        input  SEG, DIG, PEND, FRAME
    );

    modport slave (
        input  LD, DIN, DP_IN,
        output SEG, DIG, PEND, FRAME
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// seven_segment_scan_driver
//
// Time-multiplexed driver for a bank of DIGITS seven-segment digits. Values
// are loaded into a shadow register and only copied into the displayed
// register at the end of a scan frame, so one frame never mixes old and new
// digits. One digit is enabled at a time for PRESCALE clock cycles.
//
// Parameters
//   DIGITS    number of digits scanned (1..8)
//   PRESCALE  clock cycles each digit stays enabled (>= 2)
//
// Ports
//   CLK   clock, all state changes on the rising edge
//   RSTN  asynchronous active-low reset
//   bus   seven_segment_scan_driver_if.slave (LD, DIN, DP_IN in;
//         SEG, DIG, PEND, FRAME out, all outputs registered)
//
// Optional feature
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN : when defined, a digit k>0 whose nibble
//   and all higher nibbles are zero shows no segments (dp still shown).
//   Digit 0 is never blanked. Undefined by default.
// ---------------------------------------------------------------------------
module seven_segment_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    seven_segment_scan_driver_if.slave    bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIB_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Hex nibble to segments a..g (bit 6 = a, bit 0 = g), 1 = lit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    // State
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [IDX_W-1:0]  idx_q,        idx_d;
    logic [NIB_W-1:0]  shadow_nib_q, shadow_nib_d;
    logic [DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
    logic [NIB_W-1:0]  disp_nib_q,   disp_nib_d;
    logic [DIGITS-1:0] disp_dp_q,    disp_dp_d;
    logic              pend_q,       pend_d;
    logic              frame_q,      frame_d;
    logic [7:0]        seg_q,        seg_d;
    logic [DIGITS-1:0] dig_q,        dig_d;

    // Combinational helpers
    logic              step_s;
    logic              commit_s;
    logic [3:0]        nib_s;
    logic              dp_s;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic              upper_zero_s;
`endif

    // Step on the last prescaler count; commit when stepping off the last digit.
    assign step_s   = (cnt_q == CNT_LAST);
    assign commit_s = step_s && (idx_q == IDX_LAST);

    // Next-state for prescaler, digit index, shadow, display, PEND and FRAME.
    always_comb begin
        if (step_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (step_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end

        if (bus.LD) begin
            shadow_nib_d = bus.DIN;
            shadow_dp_d  = bus.DP_IN;
        end else begin
            shadow_nib_d = shadow_nib_q;
            shadow_dp_d  = shadow_dp_q;
        end

        // A load on the commit edge bypasses the shadow so it is not lost
        // for a whole frame, and PEND stays clear because it is already shown.
        if (commit_s) begin
            if (bus.LD) begin
                disp_nib_d = bus.DIN;
                disp_dp_d  = bus.DP_IN;
            end else begin
                disp_nib_d = shadow_nib_q;
                disp_dp_d  = shadow_dp_q;
            end
            pend_d = 1'b0;
        end else begin
            disp_nib_d = disp_nib_q;
            disp_dp_d  = disp_dp_q;
            if (bus.LD) begin
                pend_d = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end

        frame_d = commit_s;
    end

    // Output decode from the next index and next display value, so digit 0
    // on a commit edge already shows the freshly committed frame.
    always_comb begin
        nib_s = 4'h0;
        dp_s  = 1'b0;
        dig_d = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            nib_s    = (idx_d == IDX_W'(k)) ? disp_nib_d[4*k +: 4] : nib_s;
            dp_s     = (idx_d == IDX_W'(k)) ? disp_dp_d[k]         : dp_s;
            dig_d[k] = (idx_d == IDX_W'(k));
        end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        // Active digit is a leading zero when it and every higher nibble is 0.
        upper_zero_s = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            upper_zero_s = ((IDX_W'(k) >= idx_d) && (disp_nib_d[4*k +: 4] != 4'h0))
                           ? 1'b0 : upper_zero_s;
        end
        if ((idx_d != {IDX_W{1'b0}}) && upper_zero_s) begin
            seg_d = {7'b0000000, dp_s};
        end else begin
            seg_d = {hex_to_seg(nib_s), dp_s};
        end
`else
        seg_d = {hex_to_seg(nib_s), dp_s};
`endif
    end

    // State and registered outputs; async reset blanks the display.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            shadow_nib_q <= {NIB_W{1'b0}};
            shadow_dp_q  <= {DIGITS{1'b0}};
            disp_nib_q   <= {NIB_W{1'b0}};
            disp_dp_q    <= {DIGITS{1'b0}};
            pend_q       <= 1'b0;
            frame_q      <= 1'b0;
            seg_q        <= 8'h00;
            dig_q        <= {DIGITS{1'b0}};
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_nib_q <= shadow_nib_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_nib_q   <= disp_nib_d;
            disp_dp_q    <= disp_dp_d;
            pend_q       <= pend_d;
            frame_q      <= frame_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign bus.SEG   = seg_q;
    assign bus.DIG   = dig_q;
    assign bus.PEND  = pend_q;
    assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scan_driver
//
// DIGITS=4, PRESCALE=4. The reference model counts rising edges since reset
// release (n): the active digit is (n/PRESCALE)%DIGITS and edge n commits
// when n is a multiple of DIGITS*PRESCALE. Shadow/display/PEND are tracked
// as plain values. Directed phases pin the model with literal segment codes,
// then a randomized phase loads random values at random times.
// ---------------------------------------------------------------------------
module tb_seven_segment_scan_driver;

    localparam int D = 4;
    localparam int P = 4;
    localparam int FRAME_LEN = D * P;

    logic clk;
    logic rst_n;

    seven_segment_scan_driver_if #(.DIGITS(D)) bus ();

    seven_segment_scan_driver #(
        .DIGITS   (D),
        .PRESCALE (P)
    ) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment table a..g, straight from the hex glyph definitions.
    logic [6:0] seg7 [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                              7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                              7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                              7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic [7:0] lit1234 [4] = '{8'h66, 8'hF3, 8'hDA, 8'h60};
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] lit0050 [4] = '{8'hFC, 8'hB6, 8'h00, 8'h00};
`else
    logic [7:0] lit0050 [4] = '{8'hFC, 8'hB6, 8'hFC, 8'hFC};
`endif

    int tests = 0;
    int fails = 0;

    // Model state
    int          n;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sdp, m_ddp;
    logic        m_pend;
    logic        m_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_shadow = 16'h0000;
        m_disp   = 16'h0000;
        m_sdp    = 4'h0;
        m_ddp    = 4'h0;
        m_pend   = 1'b0;
        m_frame  = 1'b0;
    endtask

    task automatic model_edge(input logic ld, input logic [15:0] din, input logic [3:0] dp);
        n++;
        m_frame = ((n % FRAME_LEN) == 0);
        if (m_frame) begin
            m_disp = ld ? din : m_shadow;
            m_ddp  = ld ? dp  : m_sdp;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            m_shadow = din;
            m_sdp    = dp;
        end
    endtask

    function automatic int cur_digit();
        return (n / P) % D;
    endfunction

    function automatic logic [7:0] exp_seg(input int k);
        logic [15:0] upper;
        logic [3:0]  nib;
        logic        blank;
        upper = m_disp >> (4 * k);
        nib   = upper[3:0];
        blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (k > 0 && upper == 16'h0000) blank = 1'b1;
`endif
        return {blank ? 7'b0000000 : seg7[nib], m_ddp[k]};
    endfunction

    task automatic compare_model();
        logic [3:0] exp_dig;
        exp_dig = 4'(1 << cur_digit());
        chk("model_dig",   {28'h0, bus.DIG},   {28'h0, exp_dig});
        chk("model_seg",   {24'h0, bus.SEG},   {24'h0, exp_seg(cur_digit())});
        chk("model_pend",  {31'h0, bus.PEND},  {31'h0, m_pend});
        chk("model_frame", {31'h0, bus.FRAME}, {31'h0, m_frame});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_seg"},   {24'h0, bus.SEG},   32'h0000_0000);
        chk({tag, "_dig"},   {28'h0, bus.DIG},   32'h0000_0000);
        chk({tag, "_pend"},  {31'h0, bus.PEND},  32'h0000_0000);
        chk({tag, "_frame"}, {31'h0, bus.FRAME}, 32'h0000_0000);
    endtask

    // One clock cycle: drive inputs, advance model on the edge, compare after it.
    task automatic cycle(input logic ld, input logic [15:0] din, input logic [3:0] dp);
        bus.LD    = ld;
        bus.DIN   = din;
        bus.DP_IN = dp;
        @(posedge clk);
        model_edge(ld, din, dp);
        #1;
        compare_model();
        bus.LD = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0000, 4'h0);
    endtask

    // Advance until the next edge is a commit edge.
    task automatic run_to_before_commit();
        while (((n + 1) % FRAME_LEN) != 0) idle();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ld;
        logic [15:0] din;
        logic [3:0]  dp;

        model_reset();
        rst_n     = 1'b0;
        bus.LD    = 1'b0;
        bus.DIN   = 16'h0000;
        bus.DP_IN = 4'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("first_dig", {28'h0, bus.DIG}, 32'h0000_0001);
        chk("first_seg", {24'h0, bus.SEG}, 32'h0000_00FC);

        // Plain scan across two frames
        for (int i = 0; i < 2 * FRAME_LEN; i++) idle();

        // Mid-frame load, visible only from the commit onwards
        while ((n % FRAME_LEN) != 6) idle();
        cycle(1'b1, 16'h1234, 4'b0010);
        chk("pend_after_ld", {31'h0, bus.PEND}, 32'h0000_0001);
        run_to_before_commit();
        idle();
        chk("commit_frame", {31'h0, bus.FRAME}, 32'h0000_0001);
        chk("commit_pend",  {31'h0, bus.PEND},  32'h0000_0000);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk("lit_1234", {24'h0, bus.SEG}, {24'h0, lit1234[cur_digit()]});
            idle();
        end

        // Two loads before the boundary: last one wins
        while ((n % FRAME_LEN) != 3) idle();
        cycle(1'b1, 16'hAAAA, 4'b1111);
        idle();
        cycle(1'b1, 16'h00F0, 4'b0000);
        run_to_before_commit();
        idle();
        while (cur_digit() != 1) idle();
        chk("lit_00F0_d1", {24'h0, bus.SEG}, 32'h0000_008E);

        // Load exactly on the commit edge
        run_to_before_commit();
        cycle(1'b1, 16'h0050, 4'b0000);
        chk("commit_ld_pend",  {31'h0, bus.PEND},  32'h0000_0000);
        chk("commit_ld_frame", {31'h0, bus.FRAME}, 32'h0000_0001);
        for (int i = 0; i < FRAME_LEN; i++) begin
            chk("lit_0050", {24'h0, bus.SEG}, {24'h0, lit0050[cur_digit()]});
            idle();
        end

        // Randomized loads, some with zero-heavy values for leading-zero cases
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(7) == 0);
            din = 16'($urandom);
            if ($urandom_range(2) == 0) din = din & 16'h00FF;
            dp  = 4'($urandom_range(15));
            cycle(ld, din, dp);
        end

        // Reset mid-frame with a pending load
        while ((n % FRAME_LEN) != 5) idle();
        cycle(1'b1, 16'h9876, 4'b0101);
        chk("pend_before_rst", {31'h0, bus.PEND}, 32'h0000_0001);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("after_rst_dig",  {28'h0, bus.DIG},  32'h0000_0001);
        chk("after_rst_seg",  {24'h0, bus.SEG},  32'h0000_00FC);
        chk("after_rst_pend", {31'h0, bus.PEND}, 32'h0000_0000);
        for (int i = 0; i < FRAME_LEN + 2; i++) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
